// File: rtl/tlc_detect.sv
// Vehicle loop sensor conditioning for the traffic light controller: synchronize,
// debounce, stretch demand after release, count arrivals and flag stuck sensors.
module tlc_detect #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned STUCK_CYCLES = 200
) (
    input  logic       CLK,
    input  logic       clr,
    input  logic       MS_RAW,
    input  logic       SS_RAW,
    input  logic       MCNT_CLR,
    input  logic       SCNT_CLR,
    output logic       MD,
    output logic       SD,
    output logic [3:0] MCNT,
    output logic [3:0] SCNT,
    output logic       MFLT,
    output logic       SFLT
);

    localparam logic [3:0] DEB_L   = 4'(DEB_CYCLES);
    localparam logic [7:0] HOLD_L  = 8'(HOLD_CYCLES);
    localparam logic [7:0] STUCK_L = 8'(STUCK_CYCLES);

    // Channel index 0 is main street, 1 is side street.
    logic [1:0] raw;
    logic [1:0] cnt_clr;

    logic [1:0] sync_q    [2];
    logic [1:0] sync_d    [2];
    logic [3:0] deb_cnt_q [2];
    logic [3:0] deb_cnt_d [2];
    logic [3:0] cnt_q     [2];
    logic [3:0] cnt_d     [2];
    logic [7:0] hold_q    [2];
    logic [7:0] hold_d    [2];
    logic [7:0] stk_q     [2];
    logic [7:0] stk_d     [2];
    logic [1:0] deb_q;
    logic [1:0] deb_d;
    logic [1:0] flt_q;
    logic [1:0] flt_d;

    assign raw     = {SS_RAW, MS_RAW};
    assign cnt_clr = {SCNT_CLR, MCNT_CLR};

    always_comb begin
        logic rise;
        logic fall;
        deb_d = deb_q;
        flt_d = flt_q;
        for (int i = 0; i < 2; i++) begin
            sync_d[i]    = {sync_q[i][0], raw[i]};
            deb_cnt_d[i] = '0;
            hold_d[i]    = hold_q[i];
            cnt_d[i]     = cnt_q[i];
            stk_d[i]     = '0;

            // The edge that would bring the counter to DEB_CYCLES commits the new level.
            if (sync_q[i][1] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_L - 4'd1) begin
                    deb_d[i] = sync_q[i][1];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
                end
            end

            rise = deb_d[i] & ~deb_q[i];
            fall = ~deb_d[i] & deb_q[i];

            if (fall) begin
                hold_d[i] = HOLD_L;
            end else if (rise) begin
                hold_d[i] = '0;
            end else if (hold_q[i] != 8'd0) begin
                hold_d[i] = hold_q[i] - 8'd1;
            end

            // A clear coinciding with an arrival keeps that arrival.
            if (cnt_clr[i]) begin
                cnt_d[i] = {3'b000, rise};
            end else if (rise && cnt_q[i] != 4'hF) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end

            if (deb_q[i]) begin
                stk_d[i] = (stk_q[i] == STUCK_L) ? stk_q[i] : stk_q[i] + 8'd1;
            end
            flt_d[i] = flt_q[i] | (stk_d[i] == STUCK_L);
        end
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            deb_q <= '0;
            flt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                sync_q[i]    <= '0;
                deb_cnt_q[i] <= '0;
                cnt_q[i]     <= '0;
                hold_q[i]    <= '0;
                stk_q[i]     <= '0;
            end
        end else begin
            deb_q <= deb_d;
            flt_q <= flt_d;
            for (int i = 0; i < 2; i++) begin
                sync_q[i]    <= sync_d[i];
                deb_cnt_q[i] <= deb_cnt_d[i];
                cnt_q[i]     <= cnt_d[i];
                hold_q[i]    <= hold_d[i];
                stk_q[i]     <= stk_d[i];
            end
        end
    end

    // A stuck sensor forces demand so the controller never starves that approach.
    assign MD   = deb_q[0] | (hold_q[0] != 8'd0) | flt_q[0];
    assign SD   = deb_q[1] | (hold_q[1] != 8'd0) | flt_q[1];
    assign MCNT = cnt_q[0];
    assign SCNT = cnt_q[1];
    assign MFLT = flt_q[0];
    assign SFLT = flt_q[1];

endmodule

// File: tb/tb_tlc_detect.sv
// Randomized and directed bench for tlc_detect against an event-time reference model.
module tb_tlc_detect;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 200;

    logic       CLK;
    logic       clr;
    logic       MS_RAW;
    logic       SS_RAW;
    logic       MCNT_CLR;
    logic       SCNT_CLR;
    logic       MD;
    logic       SD;
    logic [3:0] MCNT;
    logic [3:0] SCNT;
    logic       MFLT;
    logic       SFLT;

    tlc_detect #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .CLK     (CLK),
        .clr     (clr),
        .MS_RAW  (MS_RAW),
        .SS_RAW  (SS_RAW),
        .MCNT_CLR(MCNT_CLR),
        .SCNT_CLR(SCNT_CLR),
        .MD      (MD),
        .SD      (SD),
        .MCNT    (MCNT),
        .SCNT    (SCNT),
        .MFLT    (MFLT),
        .SFLT    (SFLT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: debounced level changes when the last DEB synchronized samples
    // all disagree with it; hold and stuck behaviour derive from edge timestamps.
    int        cyc;
    bit        m_r1   [2];
    bit        m_r2   [2];
    bit [15:0] m_hist [2];
    int        m_nhist[2];
    bit        m_deb  [2];
    bit        m_fell [2];
    bit        m_flt  [2];
    int        m_fall [2];
    int        m_rise [2];
    int        m_cnt  [2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_r1[c]    = 0;
            m_r2[c]    = 0;
            m_hist[c]  = '0;
            m_nhist[c] = 0;
            m_deb[c]   = 0;
            m_fell[c]  = 0;
            m_flt[c]   = 0;
            m_fall[c]  = 0;
            m_rise[c]  = 0;
            m_cnt[c]   = 0;
        end
    endfunction

    function automatic void model_edge(input bit raw0, input bit raw1, input bit cc0, input bit cc1);
        cyc++;
        for (int c = 0; c < 2; c++) begin
            bit rw;
            bit cc;
            bit s;
            bit change;
            bit rise;
            rw = (c == 0) ? raw0 : raw1;
            cc = (c == 0) ? cc0 : cc1;
            s = m_r2[c];
            m_r2[c] = m_r1[c];
            m_r1[c] = rw;
            if (m_deb[c] && (cyc - m_rise[c] >= STUCK)) m_flt[c] = 1;
            m_hist[c] = {m_hist[c][14:0], s};
            if (m_nhist[c] < 16) m_nhist[c]++;
            change = (m_nhist[c] >= DEB);
            for (int k = 0; k < DEB; k++)
                if (m_hist[c][k] == m_deb[c]) change = 0;
            rise = 0;
            if (change) begin
                m_deb[c] = !m_deb[c];
                if (m_deb[c]) begin
                    rise = 1;
                    m_rise[c] = cyc;
                end else begin
                    m_fell[c] = 1;
                    m_fall[c] = cyc;
                end
            end
            if (cc) m_cnt[c] = rise ? 1 : 0;
            else if (rise && m_cnt[c] < 15) m_cnt[c]++;
        end
    endfunction

    function automatic bit exp_dem(input int c);
        return m_deb[c] | (m_fell[c] && !m_deb[c] && (cyc - m_fall[c] < HOLD)) | m_flt[c];
    endfunction

    task automatic check_all();
        chk("MD",   32'(MD),   32'(exp_dem(0)));
        chk("SD",   32'(SD),   32'(exp_dem(1)));
        chk("MCNT", 32'(MCNT), 32'(m_cnt[0]));
        chk("SCNT", 32'(SCNT), 32'(m_cnt[1]));
        chk("MFLT", 32'(MFLT), 32'(m_flt[0]));
        chk("SFLT", 32'(SFLT), 32'(m_flt[1]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_MD"},   32'(MD),   0);
        chk({tag, "_SD"},   32'(SD),   0);
        chk({tag, "_MCNT"}, 32'(MCNT), 0);
        chk({tag, "_SCNT"}, 32'(SCNT), 0);
        chk({tag, "_MFLT"}, 32'(MFLT), 0);
        chk({tag, "_SFLT"}, 32'(SFLT), 0);
    endtask

    task automatic tick(input bit ms, input bit ss, input bit mc, input bit sc);
        MS_RAW   = ms;
        SS_RAW   = ss;
        MCNT_CLR = mc;
        SCNT_CLR = sc;
        @(posedge CLK);
        model_edge(ms, ss, mc, sc);
        #1;
        check_all();
    endtask

    // Asserted mid-cycle so the outputs must drop without any clock edge.
    task automatic do_reset();
        #2;
        clr = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge CLK);
        #1;
        check_zero("rst_held");
        clr = 1'b1;
    endtask

    initial begin
        int n;
        int run [2];
        bit lvl [2];
        bit mc;
        bit sc;

        clr = 1'b0; MS_RAW = 0; SS_RAW = 0; MCNT_CLR = 0; SCNT_CLR = 0;
        cyc = 0;
        model_reset();
        #3;
        check_zero("por");
        @(posedge CLK);
        #1;
        clr = 1'b1;

        // Clean main arrival: debounced demand after e0+5.
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 0, 0);
            if (i == 4) chk("md_lat_early", 32'(MD), 0);
            if (i == 5) chk("md_lat", 32'(MD), 1);
        end
        chk("arr1_mcnt", 32'(MCNT), 1);
        chk("arr1_sd", 32'(SD), 0);

        // Short pulses are rejected.
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick((i < 3) || (i >= 8 && i < 10), 0, 0, 0);
            if (MD) n++;
        end
        chk("glitch_md_hi", 32'(n), 0);
        chk("glitch_mcnt", 32'(MCNT), 0);

        // Side demand stretched by the hold time after release.
        do_reset();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, i < 10, 0, 0);
            if (SD) n++;
        end
        chk("sd_hold_len", 32'(n), 18);
        chk("sd_hold_scnt", 32'(SCNT), 1);

        // Re-arrival during hold keeps SD continuously high.
        do_reset();
        n = 0;
        for (int i = 0; i < 48; i++) begin
            tick(0, (i < 10) || (i >= 18 && i < 28), 0, 0);
            if (i >= 5 && i <= 27 && !SD) n++;
        end
        chk("sd_gap", 32'(n), 0);
        chk("sd_rearm_scnt", 32'(SCNT), 2);

        // Count saturation, then clear coinciding with an arrival.
        do_reset();
        for (int a = 0; a < 17; a++) begin
            for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);
            for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        end
        chk("mcnt_sat", 32'(MCNT), 15);
        for (int i = 0; i < 6; i++) tick(1, 0, i == 5, 0);
        chk("mcnt_clr_arr", 32'(MCNT), 1);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);

        // Stuck main sensor: fault latches and forces demand until reset.
        do_reset();
        for (int i = 0; i < 215; i++) tick(1, 0, 0, 0);
        chk("mflt_set", 32'(MFLT), 1);
        for (int i = 0; i < 40; i++) tick(0, 0, 0, 0);
        chk("mflt_md", 32'(MD), 1);
        chk("mflt_sticky", 32'(MFLT), 1);
        do_reset();
        tick(0, 0, 0, 0);
        chk("post_flt_md", 32'(MD), 0);
        chk("post_flt_mflt", 32'(MFLT), 0);
        chk("post_flt_mcnt", 32'(MCNT), 0);

        // Randomized traffic with occasional count clears and resets.
        run[0] = 0; run[1] = 0; lvl[0] = 0; lvl[1] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (run[c] == 0) begin
                    lvl[c] = 1'($urandom_range(0, 1));
                    run[c] = $urandom_range(1, 12);
                end
                run[c]--;
            end
            mc = ($urandom_range(0, 15) == 0);
            sc = ($urandom_range(0, 15) == 0);
            tick(lvl[0], lvl[1], mc, sc);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tlc_detect.md
TLC_DETECT -- requirements
Module: tlc_detect

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a sensor change (range 1..15).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 8: cycles a detect output stays high after debounced release (range 0..255).
REQ-003 The module SHALL have parameter STUCK_CYCLES, default 200: consecutive debounced-high cycles that flag a stuck sensor (range 2..255).
REQ-004 The module SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port MS_RAW, input, 1 bit: raw main-street loop sensor, asynchronous to CLK.
REQ-007 The module SHALL have port SS_RAW, input, 1 bit: raw side-street loop sensor, asynchronous to CLK.
REQ-008 The module SHALL have ports MCNT_CLR and SCNT_CLR, input, 1 bit each: synchronous clear of the main/side vehicle counts.
REQ-009 The module SHALL have ports MD and SD, output, 1 bit each: conditioned main/side demand, feeding the traffic light controller MD/SD inputs.
REQ-010 The module SHALL have ports MCNT and SCNT, output, 4 bits each: saturating vehicle arrival counts.
REQ-011 The module SHALL have ports MFLT and SFLT, output, 1 bit each: sticky stuck-sensor fault flags.

Function (main and side channels identical and independent; main described)
REQ-012 MS_RAW SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 A debounce counter SHALL increment each cycle the synchronized value differs from the debounced state, and SHALL clear to 0 on any cycle they agree.
REQ-014 The debounced state SHALL take the synchronized value on the edge where the counter would reach DEB_CYCLES, and the counter SHALL clear on that edge.
REQ-015 Latency: a clean raw change first sampled at edge e0 SHALL appear on the debounced state after edge e0+DEB_CYCLES+1.
REQ-016 A raw pulse or glitch lasting fewer than DEB_CYCLES synchronized cycles SHALL produce no change in debounced state, MD, or MCNT.
REQ-017 A hold counter SHALL load HOLD_CYCLES on a debounced 1->0 transition and decrement to 0 once per cycle.
REQ-018 MD SHALL equal debounced OR (hold counter != 0) OR MFLT.
REQ-019 A debounced 0->1 transition during hold SHALL clear the hold counter, and MD SHALL stay continuously high with no low cycle.
REQ-020 With HOLD_CYCLES=0, MD SHALL fall on the same edge the debounced state falls.
REQ-021 MCNT SHALL increment by 1 on each debounced 0->1 transition and SHALL saturate at 15 with no wrap.
REQ-022 MCNT_CLR high at an edge SHALL load MCNT with 0.
REQ-023 If MCNT_CLR and a debounced 0->1 transition occur on the same edge, MCNT SHALL load 1.
REQ-024 A stuck counter SHALL count consecutive debounced-high cycles, SHALL clear when debounced is low, and SHALL saturate at STUCK_CYCLES.
REQ-025 MFLT SHALL be set when the stuck counter reaches STUCK_CYCLES and SHALL remain set until reset, regardless of later sensor activity.
REQ-026 While MFLT is set, MD SHALL be forced high (fail-safe demand), and MCNT SHALL continue normal operation.

Reset
REQ-027 clr low SHALL immediately, without waiting for a clock edge, clear the synchronizers, debounced states, and all counters.
REQ-028 While clr is low, MD, SD, MFLT, and SFLT SHALL be 0, and MCNT and SCNT SHALL be 4'h0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL abort the operation, and after release the channel SHALL behave as from power-up.
REQ-030 No output SHALL change on the first edge after clr deasserts unless its input conditions were already met.

Verification (defaults DEB=4, HOLD=8, STUCK=200)
REQ-031 MS_RAW 0->1 held, first sampled at edge e0 -> MD=1 after edge e0+5, MCNT=1, SD=0.
REQ-032 MS_RAW 3-cycle pulse, then 2-cycle pulse -> MD stays 0 and MCNT stays 0.
REQ-033 SS_RAW high 10 cycles then low -> SD high from debounce rise until 8 cycles after debounced fall, SCNT=1.
REQ-034 SS_RAW re-asserted 3 cycles into hold -> SD never low, SCNT=2.
REQ-035 17 clean main arrivals -> MCNT=15; MCNT_CLR asserted on the edge of arrival 18 -> MCNT=1.
REQ-036 MS_RAW held high 200+ debounced cycles -> MFLT=1, then MS_RAW low -> MD stays 1 until clr pulses low, after which MD=0, MFLT=0, MCNT=0.
